// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, default line constants and sizing helpers
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ = 50000000;
    localparam int DEFAULT_BAUD     = 115200;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
    endfunction

    // Bits needed for a counter that runs 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - oversample tick generator, one-cycle pulse every DIV clocks
// Ports: clk, rst_n (async active-low), enable (count while high, else held at 0),
//        restart (force count back to 0), tick (pulse when count reaches DIV-1).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int CW = cnt_width(DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || restart) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = enable && !restart && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, 16x oversampled, mid-bit sampling, held until rx_clr
// Ports: clk, rst_n (async active-low), rx (async serial line, idle high),
//        rx_clr (read acknowledge pulse), rx_data, rx_valid, frame_err (sticky),
//        overrun (sticky), busy (FSM not idle), parity_err (sticky, UART_RX_PARITY_EN only).
// Option macro: UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rx_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = cnt_width(OVERSAMPLE);
    localparam int BW  = cnt_width(DATA_BITS);

    uart_state_t          state_q, state_d;
    logic                 rx_m, rx_s;
    logic                 tick;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick_mid, tick_last, last_bit;
    logic                 start_det, start_ok, data_smp, stop_smp;
`ifdef UART_RX_PARITY_EN
    logic                 par_smp;
    logic                 par_bit;
`endif

    // Two-flop synchronizer; reset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Restarting on start detection phase-aligns the ticks to the start edge.
    uart_baud_gen #(.DIV(DIV)) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (busy),
        .restart (start_det),
        .tick    (tick)
    );

    assign busy      = (state_q != IDLE);
    assign tick_mid  = tick && (tick_cnt == TW'(OVERSAMPLE / 2 - 1));
    assign tick_last = tick && (tick_cnt == TW'(OVERSAMPLE - 1));
    assign last_bit  = (bit_cnt == BW'(DATA_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_det = 1'b0;
        start_ok  = 1'b0;
        data_smp  = 1'b0;
        stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                // A line that is high again at mid start bit was a glitch.
                if (tick_mid) begin
                    if (!rx_s) begin
                        state_d  = DATA;
                        start_ok = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick_last) begin
                    data_smp = 1'b1;
                    if (last_bit) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_last) begin
                    par_smp = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Leaving at the stop-bit midpoint leaves half a bit to catch the next start.
                if (tick_last) begin
                    stop_smp = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            if (state_q == IDLE || start_ok) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= (tick_cnt == TW'(OVERSAMPLE - 1)) ? '0 : tick_cnt + TW'(1);
            end
            if (start_ok) begin
                bit_cnt <= '0;
            end else if (data_smp) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
            end
            // LSB arrives first, so shifting in at the MSB leaves bit 0 in place.
            if (data_smp) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit <= 1'b0;
        end else if (par_smp) begin
            par_bit <= rx_s;
        end
    end
`endif

    // Completion beats rx_clr: the new byte is kept and flags restart from this frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (stop_smp) begin
            rx_data    <= shreg;
            rx_valid   <= 1'b1;
            frame_err  <= (frame_err & ~rx_clr) | ~rx_s;
            overrun    <= (overrun | rx_valid) & ~rx_clr;
`ifdef UART_RX_PARITY_EN
            parity_err <= (parity_err & ~rx_clr) | (^shreg ^ par_bit);
`endif
        end else if (rx_clr) begin
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int BIT = 432;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
    localparam int LAT   = 4107 + 432;
`else
    localparam int NBITS = 10;
    localparam int LAT   = 4107;
`endif
    localparam int FULL = 100000;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rx     = 1'b1;
    logic       rx_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   start_cyc = 0;
    int   rise_cyc  = -1;
    logic rv_prev   = 1'b0;

    uart_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_clr     (rx_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !rv_prev && rise_cyc < 0) rise_cyc = cyc;
        rv_prev = rx_valid;
    end

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame: start, data LSB first, optional parity, stop. clr_at pulses rx_clr
    // so that it is sampled on the edge clr_at+1 cycles after the start edge.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int clr_at, input int max_cyc);
        logic [10:0] fr;
        fr = {1'b1, 1'b1, d, 1'b0};
        if (NBITS == 11) fr[9] = par;
        fr[NBITS-1] = stop;
        start_cyc = cyc;
        for (int c = 0; c < NBITS * BIT && c < max_cyc; c++) begin
            rx     = fr[c / BIT];
            rx_clr = (c == clr_at);
            @(posedge clk);
            #1;
        end
        rx_clr = 1'b0;
        rx     = 1'b1;
    endtask

    task automatic pulse_clr();
        rx_clr = 1'b1;
        tick_n(1);
        rx_clr = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick_n(1);
            n++;
        end
    endtask

    task automatic test_reset();
        tick_n(3);
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        tick_n(5);
        checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle: busy=%b valid=%b want 0 0", busy, rx_valid); end
    endtask

    task automatic test_basic();
        int lat;
        send_frame(8'hA5, 1'b0, 1'b1, -1, FULL);
        lat = rise_cyc - start_cyc;
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL a5_data: got %h want a5", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL a5_valid: got %b want 1", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL a5_ferr: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL a5_ovr: got %b want 0", overrun); end
        checks++; if (rise_cyc < 0 || lat < LAT || lat > LAT + 1) begin failures++; $display("FAIL a5_latency: got %0d want %0d..%0d", lat, LAT, LAT + 1); end
        pulse_clr();
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL a5_clr_valid: got %b want 0", rx_valid); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        tick_n(100);
        rx = 1'b1;
        tick_n(50);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_mid: got %b want 1", busy); end
        tick_n(90);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_drop: got %b want 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0, -1, FULL);
        checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL ferr_data: got %h want 3c", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ferr_valid: got %b want 1", rx_valid); end
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
        wait_idle();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_idle_timeout: busy=%b want 0", busy); end
        pulse_clr();
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ferr_clr_valid: got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clr_flag: got %b want 0", frame_err); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b0, 1'b1, -1, FULL);
        send_frame(8'h22, 1'b0, 1'b1, -1, FULL);
        checks++; if (rx_data !== 8'h22) begin failures++; $display("FAIL b2b_data: got %h want 22", rx_data); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL b2b_ovr: got %b want 1", overrun); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL b2b_ferr: got %b want 0", frame_err); end
        send_frame(8'h11, 1'b0, 1'b1, -1, FULL);
        send_frame(8'h22, 1'b0, 1'b1, LAT - 1, FULL);
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL b2b_clr_valid: got %b want 1", rx_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_clr_ovr: got %b want 0", overrun); end
        checks++; if (rx_data !== 8'h22) begin failures++; $display("FAIL b2b_clr_data: got %h want 22", rx_data); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h5A, 1'b0, 1'b1, -1, 5 * BIT + BIT / 2);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (rx_valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL midrst_flags: valid=%b ovr=%b ferr=%b want 0 0 0", rx_valid, overrun, frame_err); end
        checks++; if (rx_data !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL midrst_data_busy: data=%h busy=%b want 00 0", rx_data, busy); end
        tick_n(4);
        rst_n = 1'b1;
        tick_n(20);
        checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin failures++; $display("FAIL midrst_idle: busy=%b valid=%b want 0 0", busy, rx_valid); end
        send_frame(8'h5A, 1'b0, 1'b1, -1, FULL);
        checks++; if (rx_data !== 8'h5A) begin failures++; $display("FAIL midrst_data: got %h want 5a", rx_data); end
        checks++; if (rx_valid !== 1'b1 || frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL midrst_status: valid=%b ferr=%b ovr=%b want 1 0 0", rx_valid, frame_err, overrun); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        pulse_clr();
        send_frame(8'h07, 1'b0, 1'b1, -1, FULL);
        checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL par_bad: got %b want 1", parity_err); end
        checks++; if (rx_data !== 8'h07 || frame_err !== 1'b0) begin failures++; $display("FAIL par_bad_data: data=%h ferr=%b want 07 0", rx_data, frame_err); end
        pulse_clr();
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_clr: got %b want 0", parity_err); end
        send_frame(8'h07, 1'b1, 1'b1, -1, FULL);
        checks++; if (parity_err !== 1'b0 || rx_valid !== 1'b1) begin failures++; $display("FAIL par_good: perr=%b valid=%b want 0 1", parity_err, rx_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
